// File: rtl/rx_frame_sync_if.sv
// Receive-side bundle for rx_frame_sync: raw line input plus captured-frame outputs.
// Latency: none (signal grouping only).
// Backpressure: none; the decoder samples sample on the rising edge of sample_flag.
//
// Signals:
//   rx_in       raw asynchronous receiver bit
//   sample      last captured frame, first payload bit in the MSB
//   sample_flag frame-ready strobe, high for one tick period
//   busy        receiver is capturing or holding a frame
//   frame_count completed-frame counter, wraps at 255
interface rx_frame_sync_if #(
    parameter int FRAME_LEN = 80
);
    logic                 rx_in;
    logic [FRAME_LEN-1:0] sample;
    logic                 sample_flag;
    logic                 busy;
    logic [7:0]           frame_count;

    // Line driver / frame consumer side.
    modport master (
        output rx_in,
        input  sample,
        input  sample_flag,
        input  busy,
        input  frame_count
    );

    // Receiver side.
    modport slave (
        input  rx_in,
        output sample,
        output sample_flag,
        output busy,
        output frame_count
    );
endinterface

// File: rtl/rx_frame_sync.sv
// Receiver front end: bit-clock recovery, preamble hunt and FRAME_LEN-bit frame capture.
// Latency: 3 clocks rx_in-to-edge detect; frame output on the tick of its last payload bit.
// Backpressure: none; a preamble arriving while busy is lost, sample holds until the next frame.
//
// Ports:
//   CLOCK_50  system clock
//   reset     synchronous, active-high
//   rx        rx_frame_sync_if slave: rx_in in; sample, sample_flag, busy, frame_count out
//
// Optional build macro RX_EDGE_RESYNC_EN: when defined, line edges re-align the bit
// divider in every state (tracks transmitter drift over long frames); otherwise only
// while hunting, and the divider free-runs through CAPTURE and HOLD.
module rx_frame_sync #(
    parameter int         CLK_DIV   = 1250,
    parameter int         FRAME_LEN = 80,
    parameter logic [7:0] PREAMBLE  = 8'hA5
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    rx_frame_sync_if.slave  rx
);
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int BCNT_W = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLK_DIV - 1);
    // Loaded on an edge so the next tick lands CLK_DIV/2 clocks later (mid-bit).
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CLK_DIV - CLK_DIV / 2);
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        HUNT,
        CAPTURE,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sync1_q, sync2_q, hist_q;
    logic [7:0]           win_q, win_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [FRAME_LEN-1:0] shadow_q, shadow_d;
    logic [FRAME_LEN-1:0] sample_q, sample_d;
    logic                 flag_q, flag_d;
    logic [7:0]           fcnt_q, fcnt_d;

    logic                 edge_det;
    logic                 resync_en;
    logic                 resync;
    logic                 tick;
    logic [7:0]           win_shift;
    logic [FRAME_LEN-1:0] shadow_shift;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        bcnt_d       = bcnt_q;
        shadow_d     = shadow_q;
        sample_d     = sample_q;
        flag_d       = flag_q;
        fcnt_d       = fcnt_q;

        edge_det     = sync2_q ^ hist_q;
`ifdef RX_EDGE_RESYNC_EN
        resync_en    = 1'b1;
`else
        resync_en    = (state_q == HUNT);
`endif
        resync       = resync_en & edge_det;
        // A resyncing edge overrides a coincident tick.
        tick         = (cnt_q == CNT_MAX) && !resync;
        win_shift    = {win_q[6:0], sync2_q};
        shadow_shift = {shadow_q[FRAME_LEN-2:0], sync2_q};

        if (resync) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (tick) begin
            unique case (state_q)
                HUNT: begin
                    win_d = win_shift;
                    if (win_shift == PREAMBLE) begin
                        state_d = CAPTURE;
                        bcnt_d  = '0;
                    end
                end
                CAPTURE: begin
                    shadow_d = shadow_shift;
                    bcnt_d   = bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BIT_LAST) begin
                        sample_d = shadow_shift;
                        flag_d   = 1'b1;
                        fcnt_d   = fcnt_q + 8'd1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    // The bit on this tick is dropped; hunting restarts from an empty window.
                    flag_d  = 1'b0;
                    win_d   = '0;
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            win_q    <= '0;
            bcnt_q   <= '0;
            shadow_q <= '0;
            sample_q <= '0;
            flag_q   <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync1_q  <= rx.rx_in;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            win_q    <= win_d;
            bcnt_q   <= bcnt_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            flag_q   <= flag_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign rx.sample      = sample_q;
    assign rx.sample_flag = flag_q;
    assign rx.busy        = (state_q != HUNT);
    assign rx.frame_count = fcnt_q;
endmodule

// File: tb/tb_rx_frame_sync.sv
// Bench for rx_frame_sync with a 16-clock bit period; line bitstreams are scanned by an
// index-based reference to predict the frames the receiver should deliver.
// Reports per-comparison FAIL lines and one closing summary.
module tb_rx_frame_sync;
    localparam int         DIV = 16;
    localparam int         FL  = 80;
    localparam logic [7:0] PRE = 8'hA5;

    localparam logic [FL-1:0] NOM_PAY = 80'h0123456789ABCDEF0123;
    localparam logic [FL-1:0] ALT_PAY = 80'hAAAAAAAAAAAAAAAAAAAA;
    localparam logic [FL-1:0] ONES    = '1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rx_frame_sync_if #(.FRAME_LEN(FL)) bus ();

    rx_frame_sync #(
        .CLK_DIV   (DIV),
        .FRAME_LEN (FL),
        .PREAMBLE  (PRE)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .rx       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [FL-1:0] obs, input logic [FL-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    bit            tx_q[$];
    logic [FL-1:0] exp_q[$];
    logic [FL-1:0] obs_q[$];
    logic          busy_hist[$];

    // Frame and strobe monitor.
    logic          prev_flag   = 1'b0;
    logic [FL-1:0] prev_sample = '0;
    int            flag_len    = 0;
    bit            busy_seen   = 1'b0;

    always @(negedge clk) begin
        if (bus.sample_flag === 1'b1 && prev_flag !== 1'b1)
            obs_q.push_back(bus.sample);
        if (!reset && bus.sample !== prev_sample)
            check("sample_change_at_flag", FL'(bus.sample_flag === 1'b1 && prev_flag !== 1'b1), 1);
        if (bus.sample_flag === 1'b1)
            flag_len++;
        else if (prev_flag === 1'b1) begin
            check("flag_len", FL'(flag_len), DIV);
            flag_len = 0;
        end
        if (bus.busy === 1'b1)
            busy_seen = 1'b1;
        prev_flag   = bus.sample_flag;
        prev_sample = bus.sample;
    end

    // Frames expected from a bitstream: find a preamble ending at bit i, take the next FL
    // bits, drop one more, and resume with an empty window.
    function automatic void model();
        int i;
        exp_q.delete();
        i = 7;
        while (i < tx_q.size()) begin
            logic [7:0] w;
            for (int k = 0; k < 8; k++) w[7-k] = tx_q[i-7+k];
            if (w == PRE) begin
                if (i + FL < tx_q.size()) begin
                    logic [FL-1:0] f;
                    for (int k = 0; k < FL; k++) f[FL-1-k] = tx_q[i+1+k];
                    exp_q.push_back(f);
                end
                i = i + FL + 2 + 7;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic push_val(input logic [FL-1:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) tx_q.push_back(v[k]);
    endtask

    task automatic push_zeros(input int n);
        repeat (n) tx_q.push_back(1'b0);
    endtask

    task automatic send_bits(input int period);
        foreach (tx_q[k]) begin
            bus.rx_in = tx_q[k];
            repeat (period) @(negedge clk);
            busy_hist.push_back(bus.busy);
        end
    endtask

    task automatic start_seg();
        obs_q.delete();
        busy_hist.delete();
        busy_seen = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.rx_in = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_sample"}, bus.sample, '0);
        check({tag, "_flag"}, FL'(bus.sample_flag), 0);
        check({tag, "_busy"}, FL'(bus.busy), 0);
        check({tag, "_count"}, FL'(bus.frame_count), 0);
        reset = 1'b0;
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_nframes"}, FL'(obs_q.size()), FL'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            check({tag, "_frame"}, (k < obs_q.size()) ? obs_q[k] : 'x, exp_q[k]);
        check({tag, "_count"}, FL'(bus.frame_count), FL'(exp_q.size() % 256));
        check({tag, "_busy_end"}, FL'(bus.busy), 0);
    endtask

    initial begin
        bus.rx_in = 1'b0;

        // Reset held while the line toggles.
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.rx_in = ~bus.rx_in;
            check("rst_sample", bus.sample, '0);
            check("rst_flag", FL'(bus.sample_flag), 0);
            check("rst_busy", FL'(bus.busy), 0);
            check("rst_count", FL'(bus.frame_count), 0);
        end
        @(negedge clk);
        bus.rx_in = 1'b0;
        reset = 1'b0;

        // Nominal frame.
        start_seg();
        tx_q.delete();
        push_zeros(4); push_val(FL'(PRE), 8); push_val(NOM_PAY, FL); push_zeros(20);
        model();
        send_bits(DIV);
        compare_frames("nominal");
        check("nominal_value", (obs_q.size() > 0) ? obs_q[0] : 'x, NOM_PAY);

        // Near-miss preamble: nothing should happen.
        do_reset("rst1");
        start_seg();
        tx_q.delete();
        push_zeros(4); push_val(FL'(8'hA4), 8); push_val(NOM_PAY, FL); push_zeros(10);
        send_bits(DIV);
        check("nearmiss_nframes", FL'(obs_q.size()), 0);
        check("nearmiss_busy_seen", FL'(busy_seen), 0);
        check("nearmiss_sample", bus.sample, '0);
        check("nearmiss_count", FL'(bus.frame_count), 0);

        // Sliding alignment: preamble completes on the 12th bit.
        do_reset("rst2");
        start_seg();
        tx_q.delete();
        push_val(FL'(4'h5), 4); push_val(FL'(PRE), 8); push_val(ONES, FL); push_zeros(90);
        model();
        send_bits(DIV);
        check("slide_busy_bit11", FL'(busy_hist[10]), 0);
        check("slide_busy_bit12", FL'(busy_hist[11]), 1);
        compare_frames("slide");
        check("slide_value", (obs_q.size() > 0) ? obs_q[0] : 'x, ONES);

        // Reset in the middle of a capture, then a clean frame.
        do_reset("rst3");
        start_seg();
        tx_q.delete();
        push_zeros(4); push_val(FL'(PRE), 8); push_val(NOM_PAY, 40);
        send_bits(DIV);
        check("midrst_busy_before", FL'(bus.busy), 1);
        do_reset("midrst");
        check("midrst_nframes", FL'(obs_q.size()), 0);
        start_seg();
        tx_q.delete();
        push_zeros(4); push_val(FL'(PRE), 8); push_val(ALT_PAY, FL); push_zeros(90);
        model();
        send_bits(DIV);
        compare_frames("after_midrst");
        check("after_midrst_value", (obs_q.size() > 0) ? obs_q[0] : 'x, ALT_PAY);

        // Randomized streams: noise, embedded preambles and random payloads.
        for (int it = 0; it < 3; it++) begin
            int nfr;
            do_reset("rst_rand");
            start_seg();
            tx_q.delete();
            push_zeros(4);
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                int noise;
                logic [FL-1:0] p;
                noise = $urandom_range(0, 24);
                repeat (noise) tx_q.push_back(1'($urandom));
                push_val(FL'(PRE), 8);
                p = {16'($urandom), $urandom, $urandom};
                push_val(p, FL);
            end
            push_zeros(90);
            model();
            send_bits(DIV);
            compare_frames("random");
        end

        // Transmitter slower than the receiver bit clock.
        do_reset("rst_drift");
        start_seg();
        tx_q.delete();
        push_zeros(4); push_val(FL'(PRE), 8); push_val(ALT_PAY, FL); push_zeros(90);
        send_bits(DIV + 1);
        check("drift_nframes", FL'(obs_q.size()), 1);
`ifdef RX_EDGE_RESYNC_EN
        check("drift_value", (obs_q.size() > 0) ? obs_q[0] : 'x, ALT_PAY);
`else
        check("drift_slip", (obs_q.size() > 0) ? FL'(obs_q[0] != ALT_PAY) : 'x, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
